// File: rtl/uart_tx_pkg.sv
// Shared UART definitions: frame state encoding, data width, default baud divider.
// Pure declarations, no logic, so there is no latency or backpressure to describe.
package uart_tx_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   localparam int UART_DATA_BITS       = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 434;

   typedef logic [UART_DATA_BITS-1:0] uart_byte_t;

endpackage

// File: rtl/uart_tx_if.sv
// Host-side byte push channel into the UART transmitter.
// Backpressure: a byte moves only on a clock edge where tx_valid && tx_ready.
interface uart_tx_if;
   import uart_tx_pkg::*;

   uart_byte_t tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (output tx_data, output tx_valid, input  tx_ready);
   modport slave  (input  tx_data, input  tx_valid, output tx_ready);

endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO between the host and the framer; a push or pop takes effect on the next edge.
// Backpressure: full_o refuses pushes, even when a pop happens in the same cycle.
module uart_tx_fifo
   import uart_tx_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  uart_byte_t               data_i,
   input  logic                     pop_i,
   output uart_byte_t               data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW-1:0] PTR_ONE = AW'(1);
   localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

   uart_byte_t    mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW:0]   count_q;
   logic          do_push;
   logic          do_pop;

   assign full_o  = (count_q == CNT_FULL);
   assign empty_o = (count_q == '0);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_ONE;
            2'b01:   count_q <= count_q - CNT_ONE;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: count_q alone decides which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, LSB first: push at edge N pops at N+1, line falls after N+2,
// frames run back to back; tx_ready drops while the TX FIFO is full.
module uart_tx
   import uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   uart_tx_if.slave                      host,
   output logic                          tx_o,
   output logic                          tx_busy_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

   uart_state_e   state_q;
   logic [CW-1:0] clk_cnt_q;
   logic [2:0]    bit_cnt_q;
   uart_byte_t    shift_q;
   logic          tx_q;

   uart_byte_t    fifo_dat;
   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_pop;
   logic          bit_done;

   assign bit_done = (clk_cnt_q == CNT_MAX);
   assign fifo_pop = !fifo_empty &&
                     ((state_q == ST_IDLE) || ((state_q == ST_STOP) && bit_done));

   uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (host.tx_valid),
      .data_i  (host.tx_data),
      .pop_i   (fifo_pop),
      .data_o  (fifo_dat),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count_o)
   );

   assign host.tx_ready = !fifo_full;
   assign tx_o          = tx_q;
   assign tx_busy_o     = (state_q != ST_IDLE) || !fifo_empty;

   // tx_q is loaded from the current state, so the line trails the FSM by one clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         clk_cnt_q <= '0;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         tx_q      <= 1'b1;
      end else begin
         case (state_q)
            ST_IDLE: begin
               tx_q <= 1'b1;
               if (fifo_pop) begin
                  shift_q   <= fifo_dat;
                  clk_cnt_q <= '0;
                  bit_cnt_q <= '0;
                  state_q   <= ST_START;
               end
            end
            ST_START: begin
               tx_q <= 1'b0;
               if (bit_done) begin
                  clk_cnt_q <= '0;
                  state_q   <= ST_DATA;
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end
            ST_DATA: begin
               tx_q <= shift_q[0];
               if (bit_done) begin
                  clk_cnt_q <= '0;
                  shift_q   <= shift_q >> 1;
                  if (bit_cnt_q == LAST_BIT) begin
                     state_q <= ST_STOP;
                  end else begin
                     bit_cnt_q <= bit_cnt_q + 3'd1;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end
            ST_STOP: begin
               tx_q <= 1'b1;
               if (bit_done) begin
                  clk_cnt_q <= '0;
                  bit_cnt_q <= '0;
                  if (fifo_pop) begin
                     shift_q <= fifo_dat;
                     state_q <= ST_START;
                  end else begin
                     state_q <= ST_IDLE;
                  end
               end else begin
                  clk_cnt_q <= clk_cnt_q + CNT_ONE;
               end
            end
            default: begin
               tx_q      <= 1'b1;
               clk_cnt_q <= '0;
               bit_cnt_q <= '0;
               state_q   <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a serial-line monitor decodes frames and checks them against a queue
// of expected bytes filled by the stimulus; directed checks cover timing, full FIFO and reset.
module tb_uart_tx;
   import uart_tx_pkg::*;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int CPB_S = 434;
   localparam int CNTW  = $clog2(DEPTH) + 1;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            tx, busy, tx_s, busy_s;
   logic [CNTW-1:0] cnt, cnt_s;

   int              n_vec  = 0;
   int              n_err  = 0;
   int              frames = 0;
   int unsigned     cyc    = 0;
   uart_byte_t      exp_q[$];
   int unsigned     starts[$];

   uart_tx_if bus ();
   uart_tx_if bus_s ();

   uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .host         (bus.slave),
      .tx_o         (tx),
      .tx_busy_o    (busy),
      .fifo_count_o (cnt)
   );

   uart_tx #(.CLKS_PER_BIT(CPB_S), .FIFO_DEPTH(DEPTH)) u_dut_slow (
      .clk          (clk),
      .rst          (rst),
      .host         (bus_s.slave),
      .tx_o         (tx_s),
      .tx_busy_o    (busy_s),
      .fifo_count_o (cnt_s)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic mon_step(inout bit ab);
      @(negedge clk);
      if (rst) ab = 1'b1;
   endtask

   // Line monitor: samples each bit one clock after its start, pops the expected byte per frame.
   initial begin : monitor
      logic [9:0]  fr;
      bit          ab;
      int unsigned t0;
      uart_byte_t  e;
      forever begin
         @(negedge clk);
         if (!rst && tx === 1'b0) begin
            t0 = cyc;
            ab = 1'b0;
            fr = '0;
            for (int k = 0; k < 10; k++) begin
               for (int j = 0; j < ((k == 0) ? 1 : CPB); j++) mon_step(ab);
               fr[k] = tx;
            end
            mon_step(ab);
            mon_step(ab);
            if (!ab) begin
               starts.push_back(t0);
               frames++;
               chk("frame_start_bit", 32'(fr[0]), 32'd0);
               chk("frame_stop_bit", 32'(fr[9]), 32'd1);
               if (exp_q.size() == 0) begin
                  n_vec++;
                  n_err++;
                  $display("FAIL frame_unexpected: got byte 0x%0h, want no frame", fr[8:1]);
               end else begin
                  e = exp_q.pop_front();
                  chk("frame_byte", 32'(fr[8:1]), 32'(e));
               end
            end
         end
      end
   end

   task automatic push(input uart_byte_t b, output int stalls, output int cnt_acc);
      bus.tx_data  = b;
      bus.tx_valid = 1'b1;
      stalls = 0;
      while (!bus.tx_ready && stalls < 500) begin
         if (stalls == 0) chk("stall_while_full_count", 32'(cnt), DEPTH);
         stalls++;
         @(negedge clk);
      end
      cnt_acc = int'(cnt);
      if (bus.tx_ready) begin
         exp_q.push_back(b);
      end else begin
         n_vec++;
         n_err++;
         $display("FAIL push_timeout: byte 0x%0h got no tx_ready, want acceptance", b);
      end
      @(negedge clk);
   endtask

   task automatic wait_fall(input int budget, output int unsigned t);
      int n = 0;
      while (tx !== 1'b0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      if (n >= budget) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_fall: got no start bit in %0d cycles, want one", budget);
      end
      t = cyc;
   endtask

   task automatic drain(input string name, input int budget);
      int n = 0;
      while ((busy || exp_q.size() != 0) && n < budget) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      chk({name, "_pending"}, exp_q.size(), 0);
      chk({name, "_busy"}, 32'(busy), 0);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int          st, ca, nonidle, f0, cur, tgt;
      int unsigned tf;
      logic [9:0]  pat;

      bus.tx_valid   = 1'b0;
      bus.tx_data    = '0;
      bus_s.tx_valid = 1'b0;
      bus_s.tx_data  = '0;

      // Reset values
      repeat (3) @(negedge clk);
      chk("rst_tx", 32'(tx), 1);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_count", 32'(cnt), 0);
      chk("rst_ready", 32'(bus.tx_ready), 1);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // Single 0x55 frame, exact line timing
      push(8'h55, st, ca);
      bus.tx_valid = 1'b0;
      @(negedge clk);
      chk("t1_tx_before_fall", 32'(tx), 1);
      @(negedge clk);
      chk("t1_tx_fall", 32'(tx), 0);
      pat = 10'b1_0101_0101_0;
      for (int k = 0; k < 10; k++) begin
         repeat ((k == 0) ? 1 : CPB) @(negedge clk);
         chk($sformatf("t1_bit%0d", k), 32'(tx), 32'(pat[k]));
      end
      @(negedge clk);
      chk("t1_busy_last_stop", 32'(busy), 1);
      @(negedge clk);
      chk("t1_busy_after_frame", 32'(busy), 0);
      drain("t1", 100);

      // Four frames back to back, no idle gap
      starts.delete();
      push(8'h00, st, ca);
      push(8'hFF, st, ca);
      push(8'hA5, st, ca);
      push(8'h3C, st, ca);
      bus.tx_valid = 1'b0;
      drain("t2", 400);
      chk("t2_frames", starts.size(), 4);
      for (int i = 1; i < starts.size(); i++)
         chk($sformatf("t2_gap%0d", i), starts[i] - starts[i-1], 10 * CPB);

      // Stream with tx_valid held: fill, stall while full, refuse push on the pop cycle
      for (int i = 0; i < 5; i++) push(8'(8'h11 + i), st, ca);
      chk("t3_fifth_no_stall", st, 0);
      chk("t3_full_count", 32'(cnt), DEPTH);
      chk("t3_full_ready", 32'(bus.tx_ready), 0);
      push(8'h16, st, ca);
      chk("t3_sixth_stalled", 32'(st > 0), 1);
      chk("t4_sixth_taken_after_pop", ca, DEPTH - 1);
      push(8'h17, st, ca);
      chk("t4_seventh_stalled", 32'(st > 0), 1);
      chk("t4_seventh_taken_after_pop", ca, DEPTH - 1);
      chk("t4_full_again", 32'(cnt), DEPTH);
      bus.tx_valid = 1'b0;
      drain("t3", 800);

      // Reset in data bit 3 with two bytes queued
      push(8'hA1, st, ca);
      push(8'hA2, st, ca);
      push(8'hA3, st, ca);
      bus.tx_valid = 1'b0;
      wait_fall(100, tf);
      chk("t5_queued", 32'(cnt), 2);
      repeat (17) @(negedge clk);
      #1 rst = 1'b1;
      exp_q.delete();
      #1;
      chk("t5_rst_tx", 32'(tx), 1);
      chk("t5_rst_count", 32'(cnt), 0);
      chk("t5_rst_busy", 32'(busy), 0);
      chk("t5_rst_ready", 32'(bus.tx_ready), 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      f0 = frames;
      nonidle = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) nonidle++;
      end
      chk("t5_idle_after_reset", nonidle, 0);
      chk("t5_no_frames", frames, f0);
      push(8'h81, st, ca);
      bus.tx_valid = 1'b0;
      drain("t5", 100);

      // Full-rate divider: 0x4D at 434 clocks per bit
      bus_s.tx_data  = 8'h4D;
      bus_s.tx_valid = 1'b1;
      chk("t6_ready", 32'(bus_s.tx_ready), 1);
      @(negedge clk);
      bus_s.tx_valid = 1'b0;
      @(negedge clk);
      chk("t6_tx_before_fall", 32'(tx_s), 1);
      @(negedge clk);
      chk("t6_tx_fall", 32'(tx_s), 0);
      pat = {1'b1, 8'h4D, 1'b0};
      cur = 0;
      for (int k = 0; k < 10; k++) begin
         tgt = CPB_S * k + CPB_S / 2;
         repeat (tgt - cur) @(negedge clk);
         cur = tgt;
         chk($sformatf("t6_bit%0d", k), 32'(tx_s), 32'(pat[k]));
         if (k == 0) begin
            repeat (CPB_S - 1 - cur) @(negedge clk);
            cur = CPB_S - 1;
            chk("t6_start_last_cycle", 32'(tx_s), 0);
            @(negedge clk);
            cur = CPB_S;
            chk("t6_bit0_first_cycle", 32'(tx_s), 1);
         end
      end
      repeat (10 * CPB_S - 2 - cur) @(negedge clk);
      chk("t6_busy_last_cycle", 32'(busy_s), 1);
      @(negedge clk);
      chk("t6_busy_after_frame", 32'(busy_s), 0);
      chk("t6_tx_idle", 32'(tx_s), 1);

      chk("end_pending", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
